bus_write_arbiter: RTL and testbench

//  Shares the single register-file write bus (BusOut + per-register WEN) between NREQ

---
 rtl/bus_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_bus_write_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter sharing one register-file write bus: IDLE -> XFER -> RECOV -> IDLE.
// Optional burst locking of the bus by one owner is enabled with `define ARB_LOCK_EN.
module bus_write_arbiter #(
   parameter int WIDTH    = 8,
   parameter int NREQ     = 4,
   parameter int NREG     = 8,
   parameter int SEL_W    = 3,
   parameter int MAX_LOCK = 4
) (
   input  logic                    Clk,
   input  logic                    RST_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic [NREQ*SEL_W-1:0]   req_sel,
   input  logic [NREQ-1:0]         req_lock,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         ack,
   output logic [WIDTH-1:0]        BusOut,
   output logic [NREG-1:0]         WEN,
   output logic                    busy,
   output logic                    sel_err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, XFER, RECOV} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     start_idx;
   logic              start;
   logic [NREQ-1:0]   grant_d;
   logic [WIDTH-1:0]  bus_d;
   logic [NREG-1:0]   wen_d;
   logic              err_d;
   logic [SEL_W-1:0]  pick_sel;

   logic [WIDTH-1:0]  data_arr [NREQ];
   logic [SEL_W-1:0]  sel_arr  [NREQ];

`ifdef ARB_LOCK_EN
   localparam int BW = $clog2(MAX_LOCK + 1);
   logic [BW-1:0]     beats_q, beats_d;
`else
   localparam int unused_max_lock = MAX_LOCK;
   logic              unused_lock;
   assign unused_lock = ^req_lock;
`endif

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = req_data[i*WIDTH +: WIDTH];
         sel_arr[i]  = req_sel[i*SEL_W +: SEL_W];
      end
   end

   // First requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin : rr_search
      logic          found;
      logic [IW-1:0] cand;
      found   = 1'b0;
      cand    = rr_q;
      win_idx = rr_q;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(rr_q) + k) % NREQ);
         if (!found && req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      start     = 1'b0;
      start_idx = owner_q;
      grant_d   = '0;
      wen_d     = '0;
      bus_d     = BusOut;
      err_d     = sel_err;
`ifdef ARB_LOCK_EN
      beats_d   = beats_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               start     = 1'b1;
               start_idx = win_idx;
`ifdef ARB_LOCK_EN
               beats_d   = BW'(1);
`endif
            end
         end
         XFER: begin
            state_d = RECOV;
            rr_d    = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
         end
         RECOV: begin
            state_d = IDLE;
`ifdef ARB_LOCK_EN
            if (req[owner_q] && req_lock[owner_q] && (beats_q < BW'(MAX_LOCK))) begin
               start     = 1'b1;
               start_idx = owner_q;
               beats_d   = beats_q + BW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      pick_sel = sel_arr[start_idx];
      if (start) begin
         state_d = XFER;
         owner_d = start_idx;
         grant_d = NREQ'(1) << start_idx;
         bus_d   = data_arr[start_idx];
         // Out-of-range destination: the beat still completes, but nothing is written.
         if (int'(pick_sel) < NREG) wen_d = NREG'(1) << pick_sel;
         else                       err_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge Clk) begin
      if (!RST_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         grant   <= '0;
         ack     <= '0;
         BusOut  <= '0;
         WEN     <= '0;
         busy    <= 1'b0;
         sel_err <= 1'b0;
`ifdef ARB_LOCK_EN
         beats_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         grant   <= grant_d;
         ack     <= grant_d;
         BusOut  <= bus_d;
         WEN     <= wen_d;
         busy    <= (state_d != IDLE);
         sel_err <= err_d;
`ifdef ARB_LOCK_EN
         beats_q <= beats_d;
`endif
      end
   end

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Self-checking bench for bus_write_arbiter: cycle model compared every cycle plus directed
// literal checks for reset, single write, round robin, bad select, mid-op reset and locking.
module tb_bus_write_arbiter;

   localparam int WIDTH = 8, NREQ = 4, NREG = 6, SEL_W = 3, MAX_LOCK = 4;
`ifdef ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic                   Clk = 1'b0;
   logic                   RST_n;
   logic [NREQ-1:0]        req, req_lock;
   logic [NREQ*WIDTH-1:0]  req_data;
   logic [NREQ*SEL_W-1:0]  req_sel;
   logic [NREQ-1:0]        grant, ack;
   logic [WIDTH-1:0]       BusOut;
   logic [NREG-1:0]        WEN;
   logic                   busy, sel_err;

   int n_tests = 0;
   int n_fail  = 0;

   bus_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .SEL_W(SEL_W),
                       .MAX_LOCK(MAX_LOCK)) dut (
      .Clk(Clk), .RST_n(RST_n), .req(req), .req_data(req_data), .req_sel(req_sel),
      .req_lock(req_lock), .grant(grant), .ack(ack), .BusOut(BusOut), .WEN(WEN),
      .busy(busy), .sel_err(sel_err));

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit               m_valid = 1'b0;
   int               m_phase, m_ptr, m_owner, m_beats;   // phase 0 idle, 1 writing, 2 turnaround
   logic [NREQ-1:0]  e_grant;
   logic [WIDTH-1:0] e_bus;
   logic [NREG-1:0]  e_wen;
   logic             e_err;

   task automatic m_start(input int w);
      logic [SEL_W-1:0] s;
      m_phase = 1;
      m_owner = w;
      e_grant = NREQ'(1) << w;
      e_bus   = req_data[w*WIDTH +: WIDTH];
      s       = req_sel[w*SEL_W +: SEL_W];
      if (int'(s) < NREG) e_wen = NREG'(1) << s;
      else                e_err = 1'b1;
   endtask

   always @(posedge Clk) begin : model
      int w;
      if (!RST_n) begin
         m_valid = 1'b1;
         m_phase = 0; m_ptr = 0; m_owner = 0; m_beats = 0;
         e_grant = '0; e_bus = '0; e_wen = '0; e_err = 1'b0;
      end else if (m_valid) begin
         e_grant = '0;
         e_wen   = '0;
         if (m_phase == 0) begin
            w = -1;
            for (int k = NREQ - 1; k >= 0; k--)
               if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w >= 0) begin
               m_beats = 1;
               m_start(w);
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
            m_ptr   = (m_owner + 1) % NREQ;
         end else begin
            if (LOCK && req[m_owner] && req_lock[m_owner] && m_beats < MAX_LOCK) begin
               m_beats++;
               m_start(m_owner);
            end else begin
               m_phase = 0;
            end
         end
      end
   end

   always @(negedge Clk) begin
      if (m_valid) begin
         check("grant",   grant,   e_grant);
         check("ack",     ack,     e_grant);
         check("BusOut",  BusOut,  e_bus);
         check("WEN",     WEN,     e_wen);
         check("busy",    busy,    m_phase != 0);
         check("sel_err", sel_err, e_err);
         check("wen_onehot0",   $onehot0(WEN),   1);
         check("grant_onehot0", $onehot0(grant), 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [NREQ-1:0] drop_en;
   int              ack_log[$];

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
      req = req & ~(ack & drop_en);
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
      req_data[i*WIDTH +: WIDTH] = d;
      req_sel[i*SEL_W +: SEL_W]  = s;
   endtask

   // Steps until n acks have been seen (returns in the cycle of the last ack) or budget expires.
   task automatic run_acks(input int n, input int budget);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < budget) begin
         step();
         cyc++;
         if (ack != '0) begin
            ack_log.push_back(onehot_idx(ack));
            got++;
         end
      end
      check("ack_budget", got, n);
   endtask

   task automatic check_order(input string name, input int k, input int exp);
      check(name, (k < ack_log.size()) ? ack_log[k] : 99, exp);
   endtask

   task automatic pulse_reset();
      RST_n = 1'b0;
      step();
      RST_n = 1'b1;
   endtask

   int exp6[5];

   initial begin
      RST_n = 1'b0; req = '1; req_lock = '0; req_data = '0; req_sel = '0; drop_en = '1;
`ifdef ARB_LOCK_EN
      exp6 = '{0, 0, 0, 0, 1};
`else
      exp6 = '{0, 1, 0, 1, 0};
`endif

      // Reset held two edges with every requester active.
      step(); step();
      check("rst_grant", grant, 0); check("rst_ack", ack, 0); check("rst_wen", WEN, 0);
      check("rst_bus", BusOut, 0);  check("rst_busy", busy, 0); check("rst_err", sel_err, 0);

      // Single write from requester 1 to register 3.
      req = '0;
      set_req(1, 8'hAA, 3'd3);
      RST_n = 1'b1;
      step();
      req = 4'b0010;
      step();
      check("single_wen", WEN, 6'h08); check("single_bus", BusOut, 8'hAA);
      check("single_ack", ack, 4'b0010); check("single_busy_x", busy, 1);
      step();
      check("recov_wen", WEN, 0); check("recov_ack", ack, 0);
      check("recov_bus", BusOut, 8'hAA); check("recov_busy", busy, 1);
      step();
      check("idle_busy", busy, 0);

      // Round robin from a fresh pointer, then a two-requester re-raise.
      pulse_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(8'h10 + i), SEL_W'(i));
      req = 4'hF;
      ack_log.delete();
      run_acks(4, 40);
      for (int k = 0; k < 4; k++) check_order("rr_order", k, k);
      req = 4'b1001;
      ack_log.delete();
      run_acks(2, 20);
      check_order("rr_reraise0", 0, 0);
      check_order("rr_reraise1", 1, 3);

      // Out-of-range destination: ack given, no write, sticky error.
      set_req(2, 8'h5C, 3'd7);
      req = 4'b0100;
      run_acks(1, 20);
      check("bad_ack", ack, 4'b0100); check("bad_wen", WEN, 0); check("bad_err", sel_err, 1);
      step(); step(); step();
      check("err_sticky", sel_err, 1);
      set_req(1, 8'h3E, 3'd1);
      req = 4'b0010;
      run_acks(1, 20);
      check("good_after_bad_wen", WEN, 6'h02); check("good_after_bad_err", sel_err, 1);

      // Reset asserted during a write beat.
      step(); step();
      set_req(0, 8'h77, 3'd4);
      req = 4'b0001;
      run_acks(1, 20);
      check("pre_rst_wen", WEN, 6'h10);
      RST_n = 1'b0;
      step();
      check("midrst_wen", WEN, 0); check("midrst_ack", ack, 0);
      check("midrst_busy", busy, 0); check("midrst_err", sel_err, 0);
      RST_n = 1'b1;
      req = 4'hF;
      ack_log.delete();
      run_acks(4, 40);
      check_order("midrst_first", 0, 0);
      step(); step(); step();

      // Lock request from requester 0 competing with requester 1.
      pulse_reset();
      drop_en = '0;
      set_req(0, 8'h55, 3'd0);
      set_req(1, 8'h66, 3'd5);
      req_lock = 4'b0001;
      req = 4'b0011;
      ack_log.delete();
      run_acks(5, 60);
      for (int k = 0; k < 5; k++) check_order("lock_order", k, exp6[k]);
      req = '0; req_lock = '0;
      step(); step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
